// File: rtl/poll_tally_controller.sv
// Poll session controller: gates one ballot per voter authorisation, keeps
// saturating per-candidate counters and, after the poll closes, scans the
// counters one candidate per clock to produce winner, winning count and tie.
module poll_tally_controller #(
    parameter int NUM_CAND = 3,
    parameter int CAND_W   = 2,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              open_poll,
    input  logic              close_poll,
    input  logic              voter_enable,
    input  logic              vote_valid,
    input  logic [CAND_W-1:0] vote_cand,
    output logic              ready_for_vote,
    output logic              vote_ack,
    output logic              vote_reject,
    output logic              busy,
    output logic              result_valid,
    output logic [CAND_W-1:0] winner_candidate,
    output logic [CNT_W-1:0]  winner_vote_count,
    output logic              tie,
    output logic              overflow,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_VOTER = 3'd1,
        ST_ARMED      = 3'd2,
        ST_TALLY      = 3'd3,
        ST_RESULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_r;
    state_t             state_nxt_s;

    logic [CNT_W-1:0]   cnt_r [NUM_CAND];
    logic [CAND_W-1:0]  scan_idx_r;
    logic [CNT_W-1:0]   best_r;
    logic [CAND_W-1:0]  best_idx_r;
    logic               scan_tie_r;

    logic [CNT_W-1:0]   scan_cnt_s;
    logic [CNT_W-1:0]   best_nxt_s;
    logic [CAND_W-1:0]  best_idx_nxt_s;
    logic               scan_tie_nxt_s;
    logic               scan_last_s;

    logic               clear_s;
    logic               vote_take_s;
    logic               cand_in_range_s;
    logic               vote_ok_s;
    logic               vote_bad_s;

    logic               ready_r;
    logic               ack_r;
    logic               reject_r;
    logic               busy_r;
    logic               result_valid_r;
    logic [CAND_W-1:0]  winner_cand_r;
    logic [CNT_W-1:0]   winner_cnt_r;
    logic               tie_r;
    logic               overflow_r;

    // Decode the qualified events of this cycle and select the counter under scan.
    always_comb begin
        cand_in_range_s = (int'(vote_cand) < NUM_CAND);
        clear_s         = open_poll && ((state_r == ST_IDLE) || (state_r == ST_RESULT));
        vote_take_s     = vote_valid && (state_r == ST_ARMED);
        vote_ok_s       = vote_take_s && cand_in_range_s;
        vote_bad_s      = vote_take_s && !cand_in_range_s;
        scan_last_s     = (int'(scan_idx_r) == (NUM_CAND - 1));
        scan_cnt_s      = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CAND; i++) begin
            scan_cnt_s = scan_cnt_s | (cnt_r[i] & {CNT_W{int'(scan_idx_r) == i}});
        end
    end

    // Running maximum update for the candidate currently under scan; the
    // strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        best_nxt_s     = best_r;
        best_idx_nxt_s = best_idx_r;
        scan_tie_nxt_s = scan_tie_r;
        if (scan_idx_r == {CAND_W{1'b0}}) begin
            best_nxt_s     = scan_cnt_s;
            best_idx_nxt_s = {CAND_W{1'b0}};
            scan_tie_nxt_s = 1'b0;
        end else if (scan_cnt_s > best_r) begin
            best_nxt_s     = scan_cnt_s;
            best_idx_nxt_s = scan_idx_r;
            scan_tie_nxt_s = 1'b0;
        end else if (scan_cnt_s == best_r) begin
            scan_tie_nxt_s = 1'b1;
        end else begin
            scan_tie_nxt_s = scan_tie_r;
        end
    end

    // Next-state logic; close_poll outranks voter_enable and a ballot is
    // processed in the same cycle that closes the poll.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (open_poll) state_nxt_s = ST_WAIT_VOTER;
                else           state_nxt_s = ST_IDLE;
            end
            ST_WAIT_VOTER: begin
                if (close_poll)        state_nxt_s = ST_TALLY;
                else if (voter_enable) state_nxt_s = ST_ARMED;
                else                   state_nxt_s = ST_WAIT_VOTER;
            end
            ST_ARMED: begin
                if (close_poll)     state_nxt_s = ST_TALLY;
                else if (vote_ok_s) state_nxt_s = ST_WAIT_VOTER;
                else                state_nxt_s = ST_ARMED;
            end
            ST_TALLY: begin
                if (scan_last_s) state_nxt_s = ST_RESULT;
                else             state_nxt_s = ST_TALLY;
            end
            ST_RESULT: begin
                if (open_poll) state_nxt_s = ST_WAIT_VOTER;
                else           state_nxt_s = ST_RESULT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Vote counters, overflow flag, tally scan and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAND; i++) cnt_r[i] <= {CNT_W{1'b0}};
            scan_idx_r     <= {CAND_W{1'b0}};
            best_r         <= {CNT_W{1'b0}};
            best_idx_r     <= {CAND_W{1'b0}};
            scan_tie_r     <= 1'b0;
            ready_r        <= 1'b0;
            ack_r          <= 1'b0;
            reject_r       <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            winner_cand_r  <= {CAND_W{1'b0}};
            winner_cnt_r   <= {CNT_W{1'b0}};
            tie_r          <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            ack_r          <= vote_ok_s;
            reject_r       <= vote_bad_s;
            ready_r        <= (state_nxt_s == ST_ARMED);
            busy_r         <= (state_nxt_s == ST_TALLY);
            result_valid_r <= (state_nxt_s == ST_RESULT);

            if (clear_s) begin
                for (int i = 0; i < NUM_CAND; i++) cnt_r[i] <= {CNT_W{1'b0}};
                overflow_r    <= 1'b0;
                tie_r         <= 1'b0;
                winner_cand_r <= {CAND_W{1'b0}};
                winner_cnt_r  <= {CNT_W{1'b0}};
            end else if (vote_ok_s) begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    if (int'(vote_cand) == i) begin
                        if (cnt_r[i] == CNT_MAX) overflow_r <= 1'b1;
                        else                     cnt_r[i]   <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end

            if (state_r == ST_TALLY) begin
                best_r     <= best_nxt_s;
                best_idx_r <= best_idx_nxt_s;
                scan_tie_r <= scan_tie_nxt_s;
                if (scan_last_s) begin
                    scan_idx_r    <= {CAND_W{1'b0}};
                    winner_cand_r <= best_idx_nxt_s;
                    winner_cnt_r  <= best_nxt_s;
                    tie_r         <= scan_tie_nxt_s;
                end else begin
                    scan_idx_r <= scan_idx_r + {{(CAND_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign ready_for_vote    = ready_r;
    assign vote_ack          = ack_r;
    assign vote_reject       = reject_r;
    assign busy              = busy_r;
    assign result_valid      = result_valid_r;
    assign winner_candidate  = winner_cand_r;
    assign winner_vote_count = winner_cnt_r;
    assign tie               = tie_r;
    assign overflow          = overflow_r;
    assign state             = state_r;

endmodule

// File: tb/tb_poll_tally_controller.sv
// Bench for poll_tally_controller: directed session scenarios plus random
// traffic, all compared cycle by cycle against a behavioural session model.
module tb_poll_tally_controller;

    localparam int NC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       open_poll = 1'b0;
    logic       close_poll = 1'b0;
    logic       voter_enable = 1'b0;
    logic       vote_valid = 1'b0;
    logic [1:0] vote_cand = 2'd0;
    logic       ready_for_vote, vote_ack, vote_reject, busy, result_valid;
    logic [1:0] winner_candidate;
    logic [3:0] winner_vote_count;
    logic       tie, overflow;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of one session.
    int m_cnt [NC];
    int m_state, m_left, m_win, m_wcnt, m_tie, m_ovf, m_ack, m_rej;

    poll_tally_controller dut (
        .clk(clk), .rst_n(rst_n), .open_poll(open_poll), .close_poll(close_poll),
        .voter_enable(voter_enable), .vote_valid(vote_valid), .vote_cand(vote_cand),
        .ready_for_vote(ready_for_vote), .vote_ack(vote_ack), .vote_reject(vote_reject),
        .busy(busy), .result_valid(result_valid), .winner_candidate(winner_candidate),
        .winner_vote_count(winner_vote_count), .tie(tie), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_state = 0; m_left = 0; m_win = 0; m_wcnt = 0;
        m_tie = 0; m_ovf = 0; m_ack = 0; m_rej = 0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_win = 0; m_wcnt = 0; m_tie = 0; m_ovf = 0;
    endfunction

    // Winner = largest count, lowest index among equals, tie if shared.
    function automatic void model_result();
        int mx, n;
        mx = 0; n = 0;
        for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
        m_win = -1;
        for (int i = 0; i < NC; i++) begin
            if (m_cnt[i] == mx) begin
                n++;
                if (m_win < 0) m_win = i;
            end
        end
        m_wcnt = mx;
        m_tie  = (n > 1) ? 1 : 0;
    endfunction

    function automatic void model_step(input int op, input int cp, input int ve, input int vv, input int vc);
        m_ack = 0; m_rej = 0;
        case (m_state)
            0: if (op != 0) begin model_clear(); m_state = 1; end
            1: begin
                if (cp != 0) begin m_state = 3; m_left = NC; end
                else if (ve != 0) m_state = 2;
            end
            2: begin
                if (vv != 0) begin
                    if (vc < NC) begin
                        if (m_cnt[vc] == 15) m_ovf = 1;
                        else m_cnt[vc] = m_cnt[vc] + 1;
                        m_ack = 1;
                        m_state = 1;
                    end else begin
                        m_rej = 1;
                    end
                end
                if (cp != 0) begin m_state = 3; m_left = NC; end
            end
            3: begin
                m_left--;
                if (m_left == 0) begin model_result(); m_state = 4; end
            end
            4: if (op != 0) begin model_clear(); m_state = 1; end
            default: m_state = 0;
        endcase
    endfunction

    task automatic check_all();
        check("state", int'(state), m_state);
        check("ready_for_vote", int'(ready_for_vote), (m_state == 2) ? 1 : 0);
        check("busy", int'(busy), (m_state == 3) ? 1 : 0);
        check("result_valid", int'(result_valid), (m_state == 4) ? 1 : 0);
        check("vote_ack", int'(vote_ack), m_ack);
        check("vote_reject", int'(vote_reject), m_rej);
        check("winner_candidate", int'(winner_candidate), m_win);
        check("winner_vote_count", int'(winner_vote_count), m_wcnt);
        check("tie", int'(tie), m_tie);
        check("overflow", int'(overflow), m_ovf);
    endtask

    // One clock: drive inputs, let the edge sample them, compare after it.
    task automatic cyc(input int op, input int cp, input int ve, input int vv, input int vc);
        open_poll    = (op != 0);
        close_poll   = (cp != 0);
        voter_enable = (ve != 0);
        vote_valid   = (vv != 0);
        vote_cand    = 2'(vc);
        @(posedge clk);
        model_step(op, cp, ve, vv, vc);
        #1;
        check_all();
    endtask

    task automatic vote(input int c);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, c);
    endtask

    task automatic close_and_wait(input string tag);
        int k;
        cyc(0, 1, 0, 0, 0);
        k = 0;
        for (int j = 1; j <= 10; j++) begin
            cyc(0, 0, 0, 0, 0);
            k = j;
            if (result_valid) break;
        end
        check({tag, "_latency"}, k, NC);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset asserted in the middle of ARMED.
        cyc(1, 0, 0, 0, 0);
        vote(0);
        cyc(0, 0, 1, 0, 0);
        check("armed_before_reset", int'(state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_state", int'(state), 0);
        check("reset_outputs", int'({ready_for_vote, vote_ack, vote_reject, busy, result_valid,
                                     winner_candidate, winner_vote_count, tie, overflow}), 0);
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        check("open_after_reset", int'(state), 1);

        // Clear winner.
        vote(0); vote(1); vote(1); vote(2); vote(2); vote(2);
        close_and_wait("clear");
        check("clear_winner", int'(winner_candidate), 2);
        check("clear_count", int'(winner_vote_count), 3);
        check("clear_tie", int'(tie), 0);

        // Tie handling.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin vote(0); vote(1); end
        vote(2); vote(2);
        close_and_wait("tie");
        check("tie_winner", int'(winner_candidate), 0);
        check("tie_count", int'(winner_vote_count), 3);
        check("tie_flag", int'(tie), 1);

        // Zero votes.
        cyc(1, 0, 0, 0, 0);
        close_and_wait("zero");
        check("zero_winner", int'(winner_candidate), 0);
        check("zero_count", int'(winner_vote_count), 0);
        check("zero_tie", int'(tie), 1);

        // Lockout and retry.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        check("lockout_no_ack", int'(vote_ack), 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 3);
        check("reject_pulse", int'(vote_reject), 1);
        check("reject_stays_armed", int'(state), 2);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1);
        check("retry_ack", int'(vote_ack), 1);
        vote(1); vote(1); vote(1); vote(0); vote(2); vote(2);
        close_and_wait("lockout");
        check("lockout_winner", int'(winner_candidate), 1);
        check("lockout_count", int'(winner_vote_count), 4);

        // Saturation and restart.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) vote(0);
        close_and_wait("sat");
        check("sat_count", int'(winner_vote_count), 15);
        check("sat_overflow", int'(overflow), 1);
        cyc(1, 0, 0, 0, 0);
        check("restart_rv", int'(result_valid), 0);
        check("restart_overflow", int'(overflow), 0);
        check("restart_state", int'(state), 1);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(0, 29) == 0) ? 1 : 0,
                ($urandom_range(0, 24) == 0) ? 1 : 0,
                ($urandom_range(0, 2) == 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poll_tally_controller.md
# poll_tally_controller

Sequential controller for one polling session of the voting machine. It gates one ballot per voter authorisation, keeps a saturating per-candidate vote counter, and scans the counters one candidate per clock to find the winner, the winning count and a tie flag once the poll closes. It sits between the presiding-officer and ballot-unit inputs and the result display, and it replaces the purely combinational winner path with a handshaked, cycle-accurate sequence.

## Interface
- NUM_CAND, 3: number of candidates, 2..15
- CAND_W, 2: candidate index width, ≥ clog2(NUM_CAND)
- CNT_W, 4: vote counter width per candidate
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- open_poll  in  1  single-cycle pulse that opens a session and clears all counts
- close_poll  in  1  single-cycle pulse that ends voting and starts the tally
- voter_enable  in  1  single-cycle pulse that authorises exactly one ballot
- vote_valid  in  1  ballot strobe, sampled only in ARMED
- vote_cand  in  CAND_W  selected candidate, qualified by vote_valid
- ready_for_vote  out  1  high while in ARMED
- vote_ack  out  1  one-cycle pulse after an accepted ballot
- vote_reject  out  1  one-cycle pulse after a ballot with vote_cand ≥ NUM_CAND
- busy  out  1  high while in TALLY
- result_valid  out  1  high while in RESULT
- winner_candidate  out  CAND_W  index of the winner
- winner_vote_count  out  CNT_W  vote count of the winner
- tie  out  1  another candidate's count equals the maximum
- overflow  out  1  sticky flag: a vote arrived at a saturated counter
- state  out  3  encoded FSM state, for debug and display

## Operation
- State encodings: IDLE=0, WAIT_VOTER=1, ARMED=2, TALLY=3, RESULT=4.
- **IDLE:** counters are zero.
  - open_poll → WAIT_VOTER.
  - All other inputs are ignored.
- **WAIT_VOTER:**
  - voter_enable → ARMED.
  - close_poll → TALLY; close_poll takes priority if it arrives together with voter_enable.
  - vote_valid is ignored, so there are no unauthorised votes.
- **ARMED:**
  - vote_valid with vote_cand < NUM_CAND: that counter increments, vote_ack pulses, → WAIT_VOTER.
  - vote_valid with vote_cand ≥ NUM_CAND: no count change, vote_reject pulses, state stays ARMED so the voter can retry.
  - close_poll together with vote_valid: the vote is processed first, then → TALLY.
  - close_poll with no vote_valid: the pending authorisation is discarded, → TALLY.
  - A repeated voter_enable is ignored.
- **Counter arithmetic:**
  - Counters are unsigned CNT_W bits.
  - At 2^CNT_W−1 a counter holds its value and overflow is set. The vote is still acked.
- **TALLY:** index i runs 0..NUM_CAND−1, one candidate per cycle.
  - At i=0: best=cnt[0], idx=0, tie=0.
  - At i>0: if cnt[i] > best, then best=cnt[i], idx=i and tie=0. Else if cnt[i] == best, tie=1.
  - On ties the lowest index wins.
  - After the last index → RESULT.
  - All other inputs are ignored, including open_poll and close_poll.
- **RESULT:**
  - winner_candidate, winner_vote_count, tie and result_valid are held.
  - open_poll clears the counters, tie, overflow and the winner outputs, then → WAIT_VOTER.
  - Counters are not readable externally; results are exposed only through the winner outputs.
- **Reset:** asynchronous to IDLE from any state, including mid-TALLY or ARMED. All counters, outputs and flags go to 0.

## Timing
- Every output is registered and resets to 0; state resets to 0 (IDLE).
- A vote sampled at edge E updates its counter at E. vote_ack or vote_reject is high for the one cycle after E.
- ready_for_vote is high on the cycle after the voter_enable edge and drops on the cycle after the accepting edge.
- close_poll sampled at edge E: busy is high from E for NUM_CAND cycles. result_valid rises after edge E+NUM_CAND (3 cycles for the default configuration).
- Back-to-back voters are allowed: the next voter_enable can be sampled on the edge after the vote, so one ballot takes at least 2 cycles.
- Tally latency does not depend on the count values.

## Test plan
- **Reset values:** assert rst_n=0 mid-ARMED → state=0 immediately, all outputs 0. Release, then open_poll → state=1.
- **Clear winner:** votes c0=1, c1=2, c2=3, each preceded by voter_enable, then close_poll → result_valid 3 cycles later, winner_candidate=2, winner_vote_count=3, tie=0.
- **Tie handling:** votes c0=3, c1=3, c2=2 → winner_candidate=0, winner_vote_count=3, tie=1.
- **Zero votes:** open_poll then close_poll → winner_candidate=0, winner_vote_count=0, tie=1.
- **Lockout:**
  - vote_valid in WAIT_VOTER → no count change, no ack.
  - vote_cand=3 in ARMED → vote_reject pulse and state stays 2; a following vote_cand=1 → vote_ack.
  - A final tally of c1=4 with c0=1, c2=2 → winner_candidate=1, winner_vote_count=4.
- **Saturation and restart:**
  - 16 votes for c0 → winner_vote_count=15, overflow=1.
  - open_poll in RESULT → result_valid=0, overflow=0, state=1.
